// File: rtl/pipeline_pkg.sv
// Shared RV32I decode constants, pipeline mux encodings and field helpers.
package pipeline_pkg;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  // select_pc
  localparam logic [1:0] PcHold   = 2'd0;
  localparam logic [1:0] PcPlus4  = 2'd1;
  localparam logic [1:0] PcBranch = 2'd2;
  localparam logic [1:0] PcJalr   = 2'd3;
  // select_ir2/3/4
  localparam logic [1:0] IrPass = 2'd0;
  localparam logic [1:0] IrHold = 2'd1;
  localparam logic [1:0] IrNop  = 2'd2;
  // select_pc2/3
  localparam logic PcxPass = 1'b0;
  localparam logic PcxHold = 1'b1;
  // select_x3/y3/md3
  localparam logic [1:0] RegRf   = 2'd0;
  localparam logic [1:0] RegZ5   = 2'd1;
  localparam logic [1:0] RegHold = 2'd2;
  // select_operand1/2, select_md4
  localparam logic [1:0] FwdNone = 2'd0;
  localparam logic [1:0] FwdZ4   = 2'd1;
  localparam logic [1:0] FwdZ5   = 2'd2;
  // select_z5
  localparam logic [1:0] Z5Alu  = 2'd0;
  localparam logic [1:0] Z5Read = 2'd1;
  localparam logic [1:0] Z5Link = 2'd2;
  localparam logic [1:0] Z5Hold = 2'd3;
  // select_datawrite, select_ir5
  localparam logic DwMd4   = 1'b0;
  localparam logic DwZ5    = 1'b1;
  localparam logic Ir5Pass = 1'b0;
  localparam logic Ir5Nop  = 1'b1;

  function automatic logic [6:0] opc(input logic [31:0] ir);
    return ir[6:0];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] ir);
    return ir[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] ir);
    return ir[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] ir);
    return ir[24:20];
  endfunction

  function automatic logic writes_rd(input logic [31:0] ir);
    logic [6:0] o;
    o = ir[6:0];
    return (o == OpcLui || o == OpcAuipc || o == OpcJal || o == OpcJalr ||
            o == OpcLoad || o == OpcOpImm || o == OpcOp) && (ir[11:7] != 5'd0);
  endfunction

  // rs1 field is meaningless for U-type and JAL, so they never cause a load-use stall.
  function automatic logic uses_rs1(input logic [31:0] ir);
    logic [6:0] o;
    o = ir[6:0];
    return !(o == OpcLui || o == OpcAuipc || o == OpcJal);
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ir);
    logic [6:0] o;
    o = ir[6:0];
    return o == OpcOp || o == OpcStore || o == OpcBranch;
  endfunction

endpackage

// File: rtl/control_hazard_fwd_unit.sv
// Register-number comparisons: forwarding selects and load-use detection.
module hazard_fwd_unit
  import pipeline_pkg::*;
(
  input  logic [31:0] ir2,
  input  logic [31:0] ir3,
  input  logic [31:0] ir4,
  input  logic [31:0] ir5,
  input  logic [1:0]  dummy_unused_tie,
  output logic [1:0]  fwd_operand1,
  output logic [1:0]  fwd_operand2,
  output logic [1:0]  fwd_md4,
  output logic [1:0]  fwd_x3,
  output logic [1:0]  fwd_y3,
  output logic [1:0]  fwd_md3,
  output logic        fwd_datawrite,
  output logic        load_use
);

  // Loads in ir4 have no result yet, so only ALU-type producers forward from z4.
  function automatic logic [1:0] fwd_sel(input logic [31:0] p4, input logic [31:0] p5,
                                         input logic [4:0] rs);
    if (writes_rd(p4) && rd_of(p4) == rs && opc(p4) != OpcLoad) return FwdZ4;
    else if (writes_rd(p5) && rd_of(p5) == rs)                   return FwdZ5;
    else                                                          return FwdNone;
  endfunction

  logic unused_bits;
  assign unused_bits = ^{ir2[31:25], ir2[14:12], ir3[31:25], ir3[14:12],
                         ir4[31:25], ir4[14:12], ir5[31:25], ir5[14:12], dummy_unused_tie};

  // Forwarding selects and load-use hazard detection.
  always_comb begin
    fwd_operand1  = fwd_sel(ir4, ir5, rs1_of(ir3));
    fwd_operand2  = uses_rs2(ir3) ? fwd_sel(ir4, ir5, rs2_of(ir3)) : FwdNone;
    fwd_md4       = (opc(ir3) == OpcStore) ? fwd_sel(ir4, ir5, rs2_of(ir3)) : FwdNone;
    fwd_x3        = (writes_rd(ir5) && rd_of(ir5) == rs1_of(ir2)) ? RegZ5 : RegRf;
    fwd_y3        = (writes_rd(ir5) && uses_rs2(ir2) && rd_of(ir5) == rs2_of(ir2)) ?
                    RegZ5 : RegRf;
    fwd_md3       = fwd_y3;
    fwd_datawrite = (opc(ir4) == OpcStore) && writes_rd(ir5) && (rd_of(ir5) == rs2_of(ir4));
    load_use      = (opc(ir3) == OpcLoad) && (rd_of(ir3) != 5'd0) &&
                    ((uses_rs1(ir2) && rs1_of(ir2) == rd_of(ir3)) ||
                     (uses_rs2(ir2) && rs2_of(ir2) == rd_of(ir3)));
  end

endmodule

// File: rtl/control.sv
// Five-stage pipeline controller: stall, flush, freeze and forwarding selects.
module control
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir2_output,
  input  logic [31:0] ir3_output,
  input  logic [31:0] ir4_output,
  input  logic [31:0] ir5_output,
  input  logic [31:0] ir4_input,
  input  logic        branch_control_output,
  input  logic        backpressureslave,
  input  logic        a_ready,
  output logic [1:0]  select_pc,
  output logic [1:0]  select_ir2,
  output logic [1:0]  select_ir3,
  output logic [1:0]  select_ir4,
  output logic        select_pc2,
  output logic        select_pc3,
  output logic [1:0]  select_x3,
  output logic [1:0]  select_y3,
  output logic [1:0]  select_md3,
  output logic [1:0]  select_operand1,
  output logic [1:0]  select_operand2,
  output logic [1:0]  select_md4,
  output logic [1:0]  select_z5,
  output logic        select_datawrite,
  output logic        select_ir5,
  output logic        reg_write_enable,
  output logic        data_write_signal
);

  logic       flush_q, flush_d;
  logic [1:0] fwd_operand1, fwd_operand2, fwd_md4, fwd_x3, fwd_y3, fwd_md3;
  logic       fwd_datawrite, load_use;
  logic       freeze, redirect, ir4_store;
  logic [1:0] z5_dec;
  logic       unused_ir4_input;

  assign unused_ir4_input = ^ir4_input[31:7];

  hazard_fwd_unit u_hazard_fwd_unit (
    .ir2              (ir2_output),
    .ir3              (ir3_output),
    .ir4              (ir4_output),
    .ir5              (ir5_output),
    .dummy_unused_tie (2'b00),
    .fwd_operand1     (fwd_operand1),
    .fwd_operand2     (fwd_operand2),
    .fwd_md4          (fwd_md4),
    .fwd_x3           (fwd_x3),
    .fwd_y3           (fwd_y3),
    .fwd_md3          (fwd_md3),
    .fwd_datawrite    (fwd_datawrite),
    .load_use         (load_use)
  );

  // Hazard classification and writeback-source decode from ir4.
  always_comb begin
    ir4_store = opc(ir4_output) == OpcStore;
    freeze    = backpressureslave ||
                ((opc(ir4_input) == OpcLoad || opc(ir4_input) == OpcStore) && !a_ready);
    redirect  = branch_control_output || (opc(ir4_output) == OpcJalr);
    if (opc(ir4_output) == OpcLoad)                                    z5_dec = Z5Read;
    else if (opc(ir4_output) == OpcJal || opc(ir4_output) == OpcJalr)  z5_dec = Z5Link;
    else                                                               z5_dec = Z5Alu;
  end

  // Priority: reset > freeze > redirect > load-use > normal.
  always_comb begin
    select_pc         = PcPlus4;
    select_ir2        = IrPass;
    select_ir3        = IrPass;
    select_ir4        = IrPass;
    select_pc2        = PcxPass;
    select_pc3        = PcxPass;
    select_x3         = fwd_x3;
    select_y3         = fwd_y3;
    select_md3        = fwd_md3;
    select_operand1   = fwd_operand1;
    select_operand2   = fwd_operand2;
    select_md4        = fwd_md4;
    select_z5         = z5_dec;
    select_datawrite  = fwd_datawrite ? DwZ5 : DwMd4;
    select_ir5        = Ir5Pass;
    reg_write_enable  = writes_rd(ir5_output);
    data_write_signal = ir4_store;
    flush_d           = 1'b0;
    if (reset) begin
      select_pc         = PcHold;
      select_ir2        = IrNop;
      select_ir3        = IrNop;
      select_ir4        = IrNop;
      select_ir5        = Ir5Nop;
      reg_write_enable  = 1'b0;
      data_write_signal = 1'b0;
    end else if (freeze) begin
      select_pc         = PcHold;
      select_ir2        = IrHold;
      select_ir3        = IrHold;
      select_ir4        = IrHold;
      select_pc2        = PcxHold;
      select_pc3        = PcxHold;
      select_x3         = RegHold;
      select_y3         = RegHold;
      select_md3        = RegHold;
      select_z5         = Z5Hold;
      select_ir5        = Ir5Nop;
      data_write_signal = 1'b0;
      flush_d           = flush_q;
    end else if (redirect) begin
      select_pc  = branch_control_output ? PcBranch : PcJalr;
      select_ir2 = IrNop;
      select_ir3 = IrNop;
      select_ir4 = IrNop;
      flush_d    = 1'b1;
    end else begin
      if (load_use) begin
        select_pc  = PcHold;
        select_pc2 = PcxHold;
        select_ir2 = IrHold;
        select_ir3 = IrNop;
        select_x3  = RegHold;
        select_y3  = RegHold;
        select_md3 = RegHold;
      end
      // The instruction fetched in the redirect cycle is on the wrong path.
      if (flush_q) select_ir2 = IrNop;
    end
  end

  // Flush-pending flag, the only state in the controller.
  always_ff @(posedge clk) begin
    if (reset) flush_q <= 1'b0;
    else       flush_q <= flush_d;
  end

endmodule

// File: tb/tb_control.sv
// Directed bench for the pipeline controller with hand-computed expectations.
module tb_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir2_output, ir3_output, ir4_output, ir5_output, ir4_input;
  logic        branch_control_output, backpressureslave, a_ready;
  logic [1:0]  select_pc, select_ir2, select_ir3, select_ir4;
  logic        select_pc2, select_pc3;
  logic [1:0]  select_x3, select_y3, select_md3;
  logic [1:0]  select_operand1, select_operand2, select_md4, select_z5;
  logic        select_datawrite, select_ir5, reg_write_enable, data_write_signal;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] Nop       = 32'h0000_0013;
  localparam logic [31:0] AddX3X1X2 = 32'h0020_81B3;
  localparam logic [31:0] SubX4X3X5 = 32'h4051_8233;
  localparam logic [31:0] LwX2X1    = 32'h0000_A103;
  localparam logic [31:0] AddX4X2X3 = 32'h0031_0233;
  localparam logic [31:0] AddiX0    = 32'h0010_0013;
  localparam logic [31:0] AddiX2X1  = 32'h0010_8113;
  localparam logic [31:0] SwX2X1    = 32'h0020_A023;
  localparam logic [31:0] JalrX1    = 32'h0000_8067;

  control dut (
    .clk                   (clk),
    .reset                 (reset),
    .ir2_output            (ir2_output),
    .ir3_output            (ir3_output),
    .ir4_output            (ir4_output),
    .ir5_output            (ir5_output),
    .ir4_input             (ir4_input),
    .branch_control_output (branch_control_output),
    .backpressureslave     (backpressureslave),
    .a_ready               (a_ready),
    .select_pc             (select_pc),
    .select_ir2            (select_ir2),
    .select_ir3            (select_ir3),
    .select_ir4            (select_ir4),
    .select_pc2            (select_pc2),
    .select_pc3            (select_pc3),
    .select_x3             (select_x3),
    .select_y3             (select_y3),
    .select_md3            (select_md3),
    .select_operand1       (select_operand1),
    .select_operand2       (select_operand2),
    .select_md4            (select_md4),
    .select_z5             (select_z5),
    .select_datawrite      (select_datawrite),
    .select_ir5            (select_ir5),
    .reg_write_enable      (reg_write_enable),
    .data_write_signal     (data_write_signal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ir2_output = Nop; ir3_output = Nop; ir4_output = Nop; ir5_output = Nop;
    ir4_input = Nop; branch_control_output = 1'b0; backpressureslave = 1'b0;
    a_ready = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    #1;
    // Reset state
    chk("rst_pc", select_pc, 0);
    chk("rst_ir2", select_ir2, 2);
    chk("rst_ir3", select_ir3, 2);
    chk("rst_ir4", select_ir4, 2);
    chk("rst_ir5", select_ir5, 1);
    chk("rst_rwe", reg_write_enable, 0);
    chk("rst_dws", data_write_signal, 0);

    reset = 1'b0;
    tick(); #1;
    chk("idle_pc", select_pc, 1);
    chk("idle_ir2", select_ir2, 0);
    chk("idle_ir5", select_ir5, 0);

    // EX->EX forwarding from ir4
    ir4_output = AddX3X1X2; ir3_output = SubX4X3X5; #1;
    chk("fwd4_op1", select_operand1, 1);
    chk("fwd4_op2", select_operand2, 0);
    chk("fwd4_pc", select_pc, 1);
    // forwarding from ir5
    ir4_output = Nop; ir5_output = AddX3X1X2; #1;
    chk("fwd5_op1", select_operand1, 2);
    chk("fwd5_rwe", reg_write_enable, 1);

    // Load-use stall
    tick(); idle();
    ir3_output = LwX2X1; ir2_output = AddX4X2X3; #1;
    chk("lu_pc", select_pc, 0);
    chk("lu_ir2", select_ir2, 1);
    chk("lu_ir3", select_ir3, 2);
    chk("lu_pc2", select_pc2, 1);
    chk("lu_pc3", select_pc3, 0);
    chk("lu_x3", select_x3, 2);
    tick(); idle();
    ir3_output = AddX4X2X3; ir4_output = Nop; ir5_output = LwX2X1; #1;
    chk("lu_after_op1", select_operand1, 2);
    chk("lu_after_pc", select_pc, 1);
    chk("lu_after_ir3", select_ir3, 0);
    ir4_output = LwX2X1; ir5_output = Nop; #1;
    chk("ld4_no_fwd", select_operand1, 0);
    chk("ld4_z5", select_z5, 1);

    // Branch redirect with trailing flush
    tick(); idle();
    branch_control_output = 1'b1; #1;
    chk("br_pc", select_pc, 2);
    chk("br_ir2", select_ir2, 2);
    chk("br_ir3", select_ir3, 2);
    chk("br_ir4", select_ir4, 2);
    tick(); branch_control_output = 1'b0; #1;
    chk("flush_ir2", select_ir2, 2);
    chk("flush_ir3", select_ir3, 0);
    chk("flush_pc", select_pc, 1);
    tick(); #1;
    chk("flush_clr_ir2", select_ir2, 0);

    // JALR redirect
    ir4_output = JalrX1; #1;
    chk("jalr_pc", select_pc, 3);
    chk("jalr_z5", select_z5, 2);
    tick(); idle(); #1;
    chk("jalr_flush_ir2", select_ir2, 2);

    // Freeze keeps a pending flush
    tick(); branch_control_output = 1'b1; #1;
    tick(); branch_control_output = 1'b0; backpressureslave = 1'b1; #1;
    chk("frz_ir2", select_ir2, 1);
    chk("frz_pc", select_pc, 0);
    tick(); backpressureslave = 1'b0; #1;
    chk("frz_flush_kept", select_ir2, 2);
    tick(); #1;
    chk("frz_flush_clr", select_ir2, 0);

    // Store waiting on address channel
    ir4_input = SwX2X1; a_ready = 1'b0; ir4_output = SwX2X1; #1;
    chk("sw_wait_pc", select_pc, 0);
    chk("sw_wait_ir5", select_ir5, 1);
    chk("sw_wait_dws", data_write_signal, 0);
    chk("sw_wait_z5", select_z5, 3);
    chk("sw_wait_x3", select_x3, 2);
    tick(); #1;
    chk("sw_wait2_pc", select_pc, 0);
    a_ready = 1'b1; #1;
    chk("sw_go_pc", select_pc, 1);
    chk("sw_go_dws", data_write_signal, 1);
    chk("sw_go_ir5", select_ir5, 0);

    // Store data forwarded from writeback
    ir5_output = AddiX2X1; #1;
    chk("dw_sel", select_datawrite, 1);
    chk("dw_rwe", reg_write_enable, 1);
    ir5_output = AddiX0; #1;
    chk("x0_rwe", reg_write_enable, 0);
    chk("x0_dw_sel", select_datawrite, 0);

    // Store in ir3 forwarding md4 / operand2 from ir4
    tick(); idle();
    ir3_output = SwX2X1; ir4_output = AddiX2X1; #1;
    chk("md4_sel", select_md4, 1);
    chk("md4_op2", select_operand2, 1);
    chk("md4_op1", select_operand1, 0);

    // Decode-stage register read bypass from ir5
    idle(); ir2_output = AddX4X2X3; ir5_output = AddiX2X1; #1;
    chk("x3_sel", select_x3, 1);
    chk("y3_sel", select_y3, 0);
    ir5_output = AddX3X1X2; #1;
    chk("y3_sel_rs2", select_y3, 1);
    chk("md3_sel_rs2", select_md3, 1);

    // Reset during a load-use stall
    tick(); idle();
    ir3_output = LwX2X1; ir2_output = AddX4X2X3; ir5_output = AddiX2X1; #1;
    chk("pre_rst_lu_pc", select_pc, 0);
    reset = 1'b1; #1;
    chk("rst_lu_pc", select_pc, 0);
    chk("rst_lu_ir2", select_ir2, 2);
    chk("rst_lu_rwe", reg_write_enable, 0);
    chk("rst_lu_dws", data_write_signal, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
